// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - parametrised pipelined ALU with valid/ready backpressure, in-band flush and result counter
module alu_pipe #(
    parameter int OP_WIDTH  = 8,
    parameter int LATENCY   = 3,
    parameter int CNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_op,
    input  logic [OP_WIDTH-1:0]     in_a,
    input  logic [OP_WIDTH-1:0]     in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*OP_WIDTH-1:0]   out_result,
    output logic                    err_op,
    output logic [CNT_WIDTH-1:0]    res_count
);

    localparam int RW    = 2 * OP_WIDTH;
    localparam int LO_W  = OP_WIDTH / 2;
    localparam int HI_W  = OP_WIDTH - LO_W;
    localparam int PPW   = OP_WIDTH + HI_W;
    localparam bit SPLIT = (LATENCY >= 2);

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_MUL = 3'd4,
        OP_SUB = 3'd5,
        OP_RST = 3'd6,
        OP_RSV = 3'd7
    } op_e;

    logic [LATENCY-1:0]         s_valid_q, s_valid_d;
    logic [LATENCY-1:0][RW-1:0] s_res_q, s_res_d;
    logic                       s0_mul_q, s0_mul_d;
    logic [PPW-1:0]             s0_pph_q, s0_pph_d;
    logic                       out_valid_q, out_valid_d;
    logic [RW-1:0]              out_result_q, out_result_d;
    logic                       err_q, err_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;

    op_e            op;
    logic           stall;
    logic           accept;
    logic           deliver;
    logic           flush;
    logic           has_result;
    logic [RW-1:0]  a_x;
    logic [RW-1:0]  b_x;
    logic [RW-1:0]  pp_lo;
    logic [PPW-1:0] pp_hi;
    logic [RW-1:0]  calc_res;

    always_comb begin
        op         = op_e'(in_op);
        stall      = out_valid_q && !out_ready;
        in_ready   = !stall;
        accept     = in_valid && in_ready;
        deliver    = out_valid_q && out_ready;
        flush      = accept && (op == OP_RST);
        has_result = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) ||
                     (op == OP_MUL) || (op == OP_SUB);
    end

    // First stage: with two or more stages the multiply is split into two
    // half-width partial products and recombined on the way to stage 1.
    always_comb begin
        a_x   = RW'(in_a);
        b_x   = RW'(in_b);
        pp_lo = RW'(in_a) * RW'(in_b[LO_W-1:0]);
        pp_hi = PPW'(in_a) * PPW'(in_b[OP_WIDTH-1:LO_W]);
        case (op)
            OP_ADD:  calc_res = a_x + b_x;
            OP_AND:  calc_res = a_x & b_x;
            OP_XOR:  calc_res = a_x ^ b_x;
            OP_MUL:  calc_res = SPLIT ? pp_lo : a_x * b_x;
            OP_SUB:  calc_res = a_x - b_x;
            default: calc_res = '0;
        endcase
    end

    always_comb begin
        s_valid_d    = s_valid_q;
        s_res_d      = s_res_q;
        s0_mul_d     = s0_mul_q;
        s0_pph_d     = s0_pph_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        err_d        = accept && (op == OP_RSV);
        cnt_d        = cnt_q + CNT_WIDTH'(deliver);

        // The whole pipe, output register included, moves as one.
        if (!stall) begin
            s_valid_d[0] = accept && has_result;
            s_res_d[0]   = calc_res;
            s0_mul_d     = (op == OP_MUL);
            s0_pph_d     = pp_hi;
            for (int i = 1; i < LATENCY; i++) begin
                s_valid_d[i] = s_valid_q[i-1];
                if (SPLIT && (i == 1) && s0_mul_q) begin
                    s_res_d[i] = s_res_q[0] + (RW'(s0_pph_q) << LO_W);
                end else begin
                    s_res_d[i] = s_res_q[i-1];
                end
            end
            out_valid_d  = s_valid_q[LATENCY-1];
            out_result_d = s_valid_q[LATENCY-1] ? s_res_q[LATENCY-1] : '0;
        end

        // A flush is only ever accepted when not stalled, so it simply overrides.
        if (flush) begin
            s_valid_d    = '0;
            out_valid_d  = 1'b0;
            out_result_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_valid_q    <= '0;
            s_res_q      <= '0;
            s0_mul_q     <= 1'b0;
            s0_pph_q     <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            s_valid_q    <= s_valid_d;
            s_res_q      <= s_res_d;
            s0_mul_q     <= s0_mul_d;
            s0_pph_q     <= s0_pph_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign err_op     = err_q;
    assign res_count  = cnt_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized and directed bench for alu_pipe against a queue-based reference model
module tb_alu_pipe;

    localparam int W  = 8;
    localparam int L  = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [2:0]    in_op = 3'd0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic          out_valid;
    logic [2*W-1:0] out_result;
    logic          err_op;
    logic [CW-1:0] res_count;

    alu_pipe #(.OP_WIDTH(W), .LATENCY(L), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .err_op     (err_op),
        .res_count  (res_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each in-flight result carries the number of non-stalled
    // edges it has seen; it is visible once that exceeds the latency.
    logic [15:0]   mres[$];
    int            mage[$];
    logic [CW-1:0] m_cnt = '0;
    logic          m_err = 1'b0;
    logic          stall_m;
    logic          acc_m;

    function automatic logic m_valid();
        return (mres.size() > 0) && (mage[0] > L);
    endfunction

    function automatic logic [15:0] ref_res(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] x;
        logic [15:0] y;
        x = {8'h00, a};
        y = {8'h00, b};
        case (op)
            3'd1:    return x + y;
            3'd2:    return x & y;
            3'd3:    return x ^ y;
            3'd4:    return x * y;
            3'd5:    return x - y;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mres.delete();
            mage.delete();
            m_cnt = '0;
            m_err = 1'b0;
        end else begin
            stall_m = m_valid() && !out_ready;
            acc_m   = in_valid && !stall_m;
            if (m_valid() && out_ready) begin
                void'(mres.pop_front());
                void'(mage.pop_front());
                m_cnt = m_cnt + 1'b1;
            end
            if (!stall_m) begin
                foreach (mage[i]) mage[i] = mage[i] + 1;
                if (acc_m && (in_op >= 3'd1) && (in_op <= 3'd5)) begin
                    mres.push_back(ref_res(in_op, in_a, in_b));
                    mage.push_back(1);
                end
            end
            if (acc_m && (in_op == 3'd6)) begin
                mres.delete();
                mage.delete();
            end
            m_err = acc_m && (in_op == 3'd7);
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, !(m_valid() && !out_ready));
        chk("out_valid", out_valid, m_valid());
        if (m_valid()) chk("out_result", out_result, mres[0]);
        chk("err_op", err_op, m_err);
        chk("res_count", res_count, m_cnt);
    end

    logic [15:0] got[$];
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) got.push_back(out_result);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic drain(input int n_exp);
        for (int n = 0; n < 20 && got.size() < n_exp; n++) step();
        step();
        chk("drain_count", got.size(), n_exp);
    endtask

    logic [2:0]  ops1 [5] = '{3'd1, 3'd4, 3'd5, 3'd3, 3'd2};
    logic [7:0]  a1   [5] = '{8'hFF, 8'hFF, 8'h01, 8'hA5, 8'hF0};
    logic [7:0]  b1   [5] = '{8'h01, 8'hFF, 8'h02, 8'h0F, 8'h3C};
    logic [15:0] exp1 [5] = '{16'h0100, 16'hFE01, 16'hFFFF, 16'h00AA, 16'h0030};
    logic [15:0] exp2 [4] = '{16'h0002, 16'h0004, 16'h0006, 16'h0008};

    initial begin
        logic [2:0] rop;

        step();
        step();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_res_count", res_count, 0);
        chk("rst_err_op", err_op, 1'b0);
        chk("rst_out_result", out_result, 0);
        rst = 1'b1;
        step();

        // Mixed ops back to back
        got.delete();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ops1[i], a1[i], b1[i]);
            step();
            if (i == 3) begin
                chk("lat_out_valid", out_valid, 1'b1);
                chk("lat_out_result", out_result, 16'h0100);
                chk("lat_res_count", res_count, 0);
            end
            if (i == 4) chk("first_deliver_count", res_count, 1);
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        drain(5);
        for (int i = 0; i < 5; i++) chk("mixed_result", (got.size() > i) ? got[i] : 16'hxxxx, exp1[i]);
        chk("mixed_count", res_count, 5);

        // Four adds with a two-cycle stall once the first result shows
        got.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd1, 8'(i + 1), 8'(i + 1));
            step();
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_out_valid", out_valid, 1'b1);
            chk("stall_out_result", out_result, 16'h0002);
            step();
        end
        out_ready = 1'b1;
        drain(4);
        for (int i = 0; i < 4; i++) chk("stall_result", (got.size() > i) ? got[i] : 16'hxxxx, exp2[i]);
        chk("stall_count", res_count, 9);

        // In-band flush
        drive(1'b1, 3'd1, 8'h01, 8'h01);
        step();
        drive(1'b1, 3'd1, 8'h02, 8'h02);
        step();
        drive(1'b1, 3'd6, 8'h00, 8'h00);
        step();
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        for (int n = 0; n < 6; n++) begin
            chk("flush_no_valid", out_valid, 1'b0);
            step();
        end
        chk("flush_count", res_count, 9);
        drive(1'b1, 3'd1, 8'h02, 8'h03);
        step();
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        step();
        step();
        chk("post_flush_early", out_valid, 1'b0);
        step();
        chk("post_flush_valid", out_valid, 1'b1);
        chk("post_flush_result", out_result, 16'h0005);
        step();
        chk("post_flush_count", res_count, 10);

        // Reserved op and no_op
        drive(1'b1, 3'd7, 8'h12, 8'h34);
        step();
        chk("err_pulse", err_op, 1'b1);
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        step();
        chk("err_one_cycle", err_op, 1'b0);
        for (int n = 0; n < 3; n++) begin
            chk("rsv_no_result", out_valid, 1'b0);
            step();
        end
        drive(1'b1, 3'd0, 8'h12, 8'h34);
        step();
        chk("nop_no_err", err_op, 1'b0);
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        for (int n = 0; n < 4; n++) begin
            chk("nop_no_result", out_valid, 1'b0);
            step();
        end

        // Asynchronous reset with work in flight and a held result
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd1, 8'h10, 8'(i));
            step();
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        out_ready = 1'b0;
        step();
        chk("pre_reset_valid", out_valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_res_count", res_count, 0);
        chk("async_out_result", out_result, 0);
        chk("async_in_ready", in_ready, 1'b1);
        step();
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            chk("post_reset_no_valid", out_valid, 1'b0);
            step();
        end

        // Randomized traffic; the count width is small so it wraps here
        for (int n = 0; n < 3000; n++) begin
            rop = 3'($urandom_range(0, 7));
            if (rop == 3'd6 && $urandom_range(0, 9) != 0) rop = 3'd4;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = rop;
            in_a      = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            in_b      = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
